// File: rtl/trig_pkg.sv
// Shared definitions for the trigger board monitoring readout path.
// Contents:
//   HIST_W      - width of one histogram word
//   HDR_MAGIC   - magic byte that opens every readout header
//   state_t     - readout sequencer states
//   make_header - builds the header word from bank geometry
package trig_pkg;

    localparam int HIST_W = 32;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SELECT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_CLEAR,
        ST_FINISH
    } state_t;

    // Header layout: magic, reserved zero byte, bin count, histogram count
    function automatic logic [HIST_W-1:0] make_header(input int nbins, input int nhist);
        logic [31:0] nb;
        logic [31:0] nh;
        nb = 32'(nbins);
        nh = 32'(nhist);
        return {HDR_MAGIC, 8'h00, nb[7:0], nh[7:0]};
    endfunction

endpackage

// File: rtl/histo_word_buf.sv
// Capture buffer for one bin's worth of histogram words.
// Ports:
//   clk, nrst  - clock and async active-low reset
//   load       - capture data_in into the buffer this cycle
//   data_in    - NHIST packed words, word h in bits [32h+31:32h]
//   idx        - selects which captured word drives 'word'
//   word       - captured word at index idx
module histo_word_buf
    import trig_pkg::*;
#(
    parameter int NHIST = 8,
    localparam int IDX_W = (NHIST > 1) ? $clog2(NHIST) : 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    load,
    input  logic [NHIST*HIST_W-1:0] data_in,
    input  logic [IDX_W-1:0]        idx,
    output logic [HIST_W-1:0]       word
);

    logic [HIST_W-1:0] words_q [NHIST];

    // Snapshot the whole bank output at once so the bank selector can move on
    // while the words are still being streamed out
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NHIST; i++) begin
                words_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NHIST; i++) begin
                words_q[i] <= data_in[i*HIST_W +: HIST_W];
            end
        end
    end

    assign word = words_q[idx];

endmodule

// File: rtl/histo_readout_seq.sv
// Readout sequencer for the monitoring histogram bank (ADC clock domain).
// Walks the bin selector across all bins, waits for the bank's registered
// output to settle, captures every histogram word of the bin and streams
// them behind a header over a valid/ready link. Optionally pulses the
// bank's histogram clear once a complete readout has gone out.
// Ports:
//   clk, nrst    - clock and async active-low reset
//   start        - one-cycle readout request (honoured only when idle)
//   clear_after  - sampled with start; request a bank clear after readout
//   abort        - cancel the readout at the next safe point
//   hist_sel     - bin selector to the bank
//   hist_data    - bank output, histogram h in bits [32h+31:32h]
//   tx_data/tx_valid/tx_ready/tx_last - outgoing word stream
//   reset_hist   - histogram clear to the bank
//   busy         - sequencer not idle
//   done         - one-cycle pulse on completion or abort
module histo_readout_seq
    import trig_pkg::*;
#(
    parameter int NHIST        = 8,
    parameter int NBINS        = 16,
    parameter int SETTLE       = 3,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    clear_after,
    input  logic                    abort,
    output logic [7:0]              hist_sel,
    input  logic [NHIST*HIST_W-1:0] hist_data,
    output logic [HIST_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    tx_last,
    output logic                    reset_hist,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (NHIST > 1) ? $clog2(NHIST) : 1;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [7:0]        BIN_LAST    = 8'(NBINS - 1);
    localparam logic [IDX_W-1:0]  H_LAST      = IDX_W'(NHIST - 1);
    localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [CW-1:0]     CLEAR_LOAD  = CW'(CLEAR_CYCLES - 1);
    localparam logic [HIST_W-1:0] HEADER_WORD = make_header(NBINS, NHIST);

    // The selector is only 8 bits wide and the counters assume at least one
    // cycle of settle and clear
    if (NBINS < 1 || NBINS > 256) begin : g_nbins_range
        $fatal(1, "histo_readout_seq: NBINS must be in 1..256");
    end
    if (NHIST < 1 || NHIST > 255) begin : g_nhist_range
        $fatal(1, "histo_readout_seq: NHIST must be in 1..255");
    end
    if (SETTLE < 1) begin : g_settle_range
        $fatal(1, "histo_readout_seq: SETTLE must be at least 1");
    end
    if (CLEAR_CYCLES < 1) begin : g_clear_range
        $fatal(1, "histo_readout_seq: CLEAR_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [7:0]       bin_q, bin_d;
    logic [7:0]       sel_q, sel_d;
    logic [IDX_W-1:0] h_q, h_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CW-1:0]    clear_cnt_q, clear_cnt_d;
    logic             clr_latch_q, clr_latch_d;
    logic             abort_pend_q, abort_pend_d;
    logic             load;
    logic             abort_now;
    logic [HIST_W-1:0] buf_word;

    histo_word_buf #(
        .NHIST (NHIST)
    ) u_word_buf (
        .clk     (clk),
        .nrst    (nrst),
        .load    (load),
        .data_in (hist_data),
        .idx     (h_q),
        .word    (buf_word)
    );

    // A request seen this cycle counts as well as one remembered earlier
    assign abort_now = abort | abort_pend_q;
    assign hist_sel  = sel_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            bin_q        <= '0;
            sel_q        <= '0;
            h_q          <= '0;
            settle_q     <= '0;
            clear_cnt_q  <= '0;
            clr_latch_q  <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            sel_q        <= sel_d;
            h_q          <= h_d;
            settle_q     <= settle_d;
            clear_cnt_q  <= clear_cnt_d;
            clr_latch_q  <= clr_latch_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state and output logic. An offered word is never withdrawn, so in
    // HEADER and SEND an abort is only acted on together with a handshake;
    // an abort on the final handshake also suppresses the clear.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        sel_d        = sel_q;
        h_d          = h_q;
        settle_d     = settle_q;
        clear_cnt_d  = clear_cnt_q;
        clr_latch_d  = clr_latch_q;
        abort_pend_d = abort_pend_q | abort;
        load         = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        reset_hist   = 1'b0;
        busy         = (state_q != ST_IDLE);
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    clr_latch_d = clear_after;
                    bin_d       = '0;
                    h_d         = '0;
                    state_d     = ST_HEADER;
                end
            end

            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_WORD;
                if (tx_ready) begin
                    state_d = abort_now ? ST_FINISH : ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else begin
                    sel_d    = bin_q;
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else if (settle_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end

            ST_CAPTURE: begin
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else begin
                    load    = 1'b1;
                    h_d     = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = buf_word;
                tx_last  = (bin_q == BIN_LAST) && (h_q == H_LAST);
                if (tx_ready) begin
                    if (abort_now) begin
                        state_d = ST_FINISH;
                    end else if (h_q != H_LAST) begin
                        h_d = h_q + 1'b1;
                    end else if (bin_q != BIN_LAST) begin
                        bin_d   = bin_q + 8'd1;
                        state_d = ST_SELECT;
                    end else if (clr_latch_q) begin
                        clear_cnt_d = CLEAR_LOAD;
                        state_d     = ST_CLEAR;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_CLEAR: begin
                reset_hist = 1'b1;
                if (clear_cnt_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    clear_cnt_d = clear_cnt_q - 1'b1;
                end
            end

            ST_FINISH: begin
                // Leave everything at idle values so the next readout starts clean
                done         = 1'b1;
                abort_pend_d = 1'b0;
                clr_latch_d  = 1'b0;
                sel_d        = '0;
                bin_d        = '0;
                h_d          = '0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
